// File: rtl/eeg_aram_burst_arb.sv
// Per-bank burst arbiter for the activation RAM: round-robin lock of one requester
// per bank for a whole burst, with credit throttling of outstanding address beats.
module eeg_aram_burst_arb #(
  parameter int REQ_NUM = 4,
  parameter int BNK_NUM = 4,
  parameter int REQ_AW  = $clog2(REQ_NUM),
  parameter int BNK_AW  = $clog2(BNK_NUM),
  parameter int OST_MAX = 2,
  parameter int OST_AW  = $clog2(OST_MAX + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REQ_NUM-1:0]        req_vld,
  input  logic [REQ_NUM-1:0]        req_lst,
  input  logic [REQ_NUM*BNK_AW-1:0] req_bid,
  output logic [REQ_NUM-1:0]        req_rdy,
  output logic [BNK_NUM-1:0]        bnk_add_vld,
  input  logic [BNK_NUM-1:0]        bnk_add_rdy,
  output logic [BNK_NUM*REQ_AW-1:0] bnk_gnt_idx,
  input  logic [BNK_NUM-1:0]        bnk_dat_ena,
  output logic [BNK_NUM-1:0]        bnk_busy,
  output logic [BNK_NUM-1:0]        bnk_err
);

  typedef enum logic {S_IDLE, S_LOCK} state_t;

  state_t              state_q [BNK_NUM];
  state_t              state_d [BNK_NUM];
  logic [REQ_AW-1:0]   owner_q [BNK_NUM];
  logic [REQ_AW-1:0]   owner_d [BNK_NUM];
  logic [REQ_AW-1:0]   rr_q    [BNK_NUM];
  logic [REQ_AW-1:0]   rr_d    [BNK_NUM];
  logic [OST_AW-1:0]   cnt_q   [BNK_NUM];
  logic [OST_AW-1:0]   cnt_d   [BNK_NUM];
  logic [BNK_NUM-1:0]  err_q;
  logic [BNK_NUM-1:0]  err_d;

  // Saturating credit update: an issue and a return in the same cycle cancel out.
  function automatic logic [OST_AW-1:0] cnt_upd(input logic [OST_AW-1:0] cnt,
                                                input logic inc, input logic dec);
    logic [OST_AW-1:0] res;
    res = cnt;
    if (inc && !dec)
      res = cnt + OST_AW'(1);
    else if (dec && !inc && cnt != '0)
      res = cnt - OST_AW'(1);
    return res;
  endfunction

  function automatic logic [REQ_AW-1:0] rr_next(input logic [REQ_AW-1:0] own);
    return (own == REQ_AW'(REQ_NUM - 1)) ? '0 : own + REQ_AW'(1);
  endfunction

  always_comb begin
    logic found;
    logic has_cred;
    logic add_ena;
    int   ii;
    req_rdy     = '0;
    bnk_add_vld = '0;
    bnk_gnt_idx = '0;
    bnk_busy    = '0;
    err_d       = err_q;
    for (int b = 0; b < BNK_NUM; b++) begin
      state_d[b] = state_q[b];
      owner_d[b] = owner_q[b];
      rr_d[b]    = rr_q[b];
      found      = 1'b0;
      add_ena    = 1'b0;
      ii         = 0;
      has_cred   = (cnt_q[b] < OST_AW'(OST_MAX));
      bnk_gnt_idx[b*REQ_AW +: REQ_AW] = owner_q[b];
      bnk_busy[b] = (state_q[b] == S_LOCK) || (cnt_q[b] != '0);
      if (state_q[b] == S_IDLE) begin
        // Search starts at the round-robin pointer and wraps.
        for (int k = 0; k < REQ_NUM; k++) begin
          ii = (int'(rr_q[b]) + k) % REQ_NUM;
          if (!found && req_vld[ii] && req_bid[ii*BNK_AW +: BNK_AW] == BNK_AW'(b)) begin
            found      = 1'b1;
            owner_d[b] = REQ_AW'(ii);
            state_d[b] = S_LOCK;
          end
        end
      end else begin
        bnk_add_vld[b] = req_vld[owner_q[b]] && has_cred;
        req_rdy[owner_q[b]] = req_rdy[owner_q[b]] | (bnk_add_rdy[b] && has_cred);
        add_ena = bnk_add_vld[b] && bnk_add_rdy[b];
        if (add_ena && req_lst[owner_q[b]]) begin
          state_d[b] = S_IDLE;
          rr_d[b]    = rr_next(owner_q[b]);
        end
      end
      cnt_d[b] = cnt_upd(cnt_q[b], add_ena, bnk_dat_ena[b]);
      if (bnk_dat_ena[b] && !add_ena && cnt_q[b] == '0)
        err_d[b] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < BNK_NUM; b++) begin
        state_q[b] <= S_IDLE;
        owner_q[b] <= '0;
        rr_q[b]    <= '0;
        cnt_q[b]   <= '0;
      end
      err_q <= '0;
    end else begin
      for (int b = 0; b < BNK_NUM; b++) begin
        state_q[b] <= state_d[b];
        owner_q[b] <= owner_d[b];
        rr_q[b]    <= rr_d[b];
        cnt_q[b]   <= cnt_d[b];
      end
      err_q <= err_d;
    end
  end

  assign bnk_err = err_q;

endmodule

// File: tb/tb_eeg_aram_burst_arb.sv
// Bench for eeg_aram_burst_arb: directed scenarios with literal expectations, then
// randomized bursts checked every cycle against a per-bank behavioural model.
module tb_eeg_aram_burst_arb;
  localparam int RN  = 4;
  localparam int BN  = 4;
  localparam int OST = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req_vld, req_lst, req_rdy;
  logic [7:0] req_bid, bnk_gnt_idx;
  logic [3:0] bnk_add_vld, bnk_add_rdy, bnk_dat_ena, bnk_busy, bnk_err;

  always #5 clk = ~clk;

  eeg_aram_burst_arb dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_lst(req_lst), .req_bid(req_bid),
    .req_rdy(req_rdy), .bnk_add_vld(bnk_add_vld), .bnk_add_rdy(bnk_add_rdy),
    .bnk_gnt_idx(bnk_gnt_idx), .bnk_dat_ena(bnk_dat_ena), .bnk_busy(bnk_busy),
    .bnk_err(bnk_err)
  );

  int errors = 0;
  int checks = 0;

  // Model: per bank, whether a requester holds it, who, where the next search starts,
  // how many beats are outstanding and whether an unmatched return was seen.
  int m_lock[BN], m_own[BN], m_rr[BN], m_cnt[BN], m_err[BN];
  int n_lock[BN], n_own[BN], n_rr[BN], n_cnt[BN], n_err[BN];
  logic [3:0] e_rdy, e_vld, e_busy, e_err;
  logic [7:0] e_gnt;
  logic [3:0] last_acc;

  int g_bid[RN], g_left[RN];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_bid(input int r, input int b);
    req_bid[r*2 +: 2] = 2'(b);
  endtask

  task automatic model_eval();
    int o;
    bit ok, acc, dat;
    e_rdy = '0; e_vld = '0; e_busy = '0; e_err = '0; e_gnt = '0;
    for (int b = 0; b < BN; b++) begin
      n_lock[b] = m_lock[b]; n_own[b] = m_own[b]; n_rr[b] = m_rr[b];
      n_cnt[b] = m_cnt[b]; n_err[b] = m_err[b];
      e_gnt[b*2 +: 2] = 2'(m_own[b]);
      e_busy[b] = (m_lock[b] != 0) || (m_cnt[b] != 0);
      e_err[b]  = (m_err[b] != 0);
      acc = 0;
      if (m_lock[b] == 0) begin
        for (int k = 0; k < RN; k++) begin
          int r;
          r = (m_rr[b] + k) % RN;
          if (n_lock[b] == 0 && req_vld[r] && int'(req_bid[r*2 +: 2]) == b) begin
            n_lock[b] = 1;
            n_own[b]  = r;
          end
        end
      end else begin
        o  = m_own[b];
        ok = m_cnt[b] < OST;
        e_vld[b] = req_vld[o] && ok;
        if (bnk_add_rdy[b] && ok) e_rdy[o] = 1'b1;
        acc = e_vld[b] && bnk_add_rdy[b];
        if (acc && req_lst[o]) begin
          n_lock[b] = 0;
          n_rr[b]   = (o + 1) % RN;
        end
      end
      dat = bnk_dat_ena[b];
      if (acc && !dat) n_cnt[b] = m_cnt[b] + 1;
      else if (dat && !acc) begin
        if (m_cnt[b] == 0) n_err[b] = 1;
        else n_cnt[b] = m_cnt[b] - 1;
      end
      if (rst) begin
        n_lock[b] = 0; n_own[b] = 0; n_rr[b] = 0; n_cnt[b] = 0; n_err[b] = 0;
      end
    end
    last_acc = req_vld & e_rdy;
  endtask

  // Called at a negedge with inputs already set: compare, then advance one clock.
  task automatic tick();
    #1;
    model_eval();
    chk("req_rdy", 32'(req_rdy), 32'(e_rdy));
    chk("bnk_add_vld", 32'(bnk_add_vld), 32'(e_vld));
    chk("bnk_gnt_idx", 32'(bnk_gnt_idx), 32'(e_gnt));
    chk("bnk_busy", 32'(bnk_busy), 32'(e_busy));
    chk("bnk_err", 32'(bnk_err), 32'(e_err));
    @(posedge clk);
    for (int b = 0; b < BN; b++) begin
      m_lock[b] = n_lock[b]; m_own[b] = n_own[b]; m_rr[b] = n_rr[b];
      m_cnt[b] = n_cnt[b]; m_err[b] = n_err[b];
    end
    @(negedge clk);
  endtask

  task automatic drain();
    req_vld = '0; req_lst = '0;
    for (int i = 0; i < 4; i++) begin
      for (int b = 0; b < BN; b++) bnk_dat_ena[b] = (m_cnt[b] > 0);
      tick();
    end
    bnk_dat_ena = '0;
  endtask

  int rr_seq[4] = '{1, 3, 1, 3};

  initial begin
    rst = 1'b1; req_vld = '0; req_lst = '0; req_bid = '0;
    bnk_add_rdy = '0; bnk_dat_ena = '0;
    for (int b = 0; b < BN; b++) begin
      m_lock[b] = 0; m_own[b] = 0; m_rr[b] = 0; m_cnt[b] = 0; m_err[b] = 0;
    end
    @(negedge clk); @(posedge clk); @(negedge clk);
    rst = 1'b0;
    bnk_add_rdy = 4'hF;
    #1;
    chk("rst_rdy", 32'(req_rdy), 32'h0);
    chk("rst_vld", 32'(bnk_add_vld), 32'h0);
    chk("rst_gnt", 32'(bnk_gnt_idx), 32'h0);
    chk("rst_busy", 32'(bnk_busy), 32'h0);
    chk("rst_err", 32'(bnk_err), 32'h0);

    // Single 3-beat burst from req0 to bank2.
    req_vld = 4'b0001; set_bid(0, 2);
    #1 chk("sb_idle_vld", 32'(bnk_add_vld), 32'h0);
    tick();
    #1;
    chk("sb_vld", 32'(bnk_add_vld), 32'b0100);
    chk("sb_rdy", 32'(req_rdy), 32'b0001);
    chk("sb_gnt", 32'(bnk_gnt_idx[5:4]), 32'h0);
    chk("sb_busy", 32'(bnk_busy), 32'b0100);
    tick();
    bnk_dat_ena = 4'b0100; tick();
    req_lst = 4'b0001; tick();
    req_vld = '0; req_lst = '0;
    #1;
    chk("sb_end_vld", 32'(bnk_add_vld), 32'h0);
    chk("sb_end_busy", 32'(bnk_busy), 32'b0100);
    tick();
    bnk_dat_ena = '0;
    #1 chk("sb_idle_busy", 32'(bnk_busy), 32'h0);
    tick();

    // Round robin between req1 and req3 on bank0, 1-beat bursts.
    req_vld = 4'b1010; req_lst = 4'b1010; set_bid(1, 0); set_bid(3, 0);
    for (int i = 0; i < 8; i++) begin
      bnk_dat_ena = {3'b000, m_cnt[0] > 0};
      #1;
      if (i % 2 == 1) begin
        chk("rr_vld", 32'(bnk_add_vld[0]), 32'h1);
        chk("rr_gnt", 32'(bnk_gnt_idx[1:0]), 32'(rr_seq[i/2]));
      end else begin
        chk("rr_bubble", 32'(bnk_add_vld[0]), 32'h0);
      end
      tick();
    end
    drain();

    // Credit stall: 4-beat burst req2 -> bank1.
    req_vld = 4'b0100; set_bid(2, 1);
    tick();
    #1 chk("cs_rdy1", 32'(req_rdy), 32'b0100);
    tick();
    tick();
    #1;
    chk("cs_blk_vld", 32'(bnk_add_vld), 32'h0);
    chk("cs_blk_rdy", 32'(req_rdy), 32'h0);
    tick();
    bnk_dat_ena = 4'b0010;
    #1 chk("cs_blk_ret", 32'(bnk_add_vld), 32'h0);
    tick();
    bnk_dat_ena = '0;
    #1 chk("cs_release", 32'(bnk_add_vld), 32'b0010);
    tick();
    #1 chk("cs_blk2", 32'(bnk_add_vld), 32'h0);
    bnk_dat_ena = 4'b0010; tick();
    req_lst = 4'b0100;
    #1 chk("cs_last_vld", 32'(bnk_add_vld), 32'b0010);
    tick();
    req_vld = '0; req_lst = '0; bnk_dat_ena = '0;
    #1 chk("cs_cnt_held", 32'(bnk_busy), 32'b0010);
    tick();
    drain();

    // Parallel banks: req0 -> bank1, req2 -> bank3.
    req_vld = 4'b0101; req_lst = 4'b0101; set_bid(0, 1); set_bid(2, 3);
    #1 chk("pb_idle", 32'(bnk_add_vld), 32'h0);
    tick();
    req_vld = 4'b0101;
    #1;
    chk("pb_vld", 32'(bnk_add_vld), 32'b1010);
    chk("pb_rdy", 32'(req_rdy), 32'b0101);
    chk("pb_gnt1", 32'(bnk_gnt_idx[3:2]), 32'h0);
    chk("pb_gnt3", 32'(bnk_gnt_idx[7:6]), 32'h2);
    tick();
    drain();

    // Unmatched return sets a sticky error.
    bnk_dat_ena = 4'b0001; tick();
    bnk_dat_ena = '0;
    #1 chk("err_set", 32'(bnk_err), 32'b0001);
    tick(); tick();
    #1 chk("err_sticky", 32'(bnk_err), 32'b0001);

    // Reset mid-burst on bank1, then re-arbitration from pointer 0.
    req_vld = 4'b0100; req_lst = '0; set_bid(2, 1);
    tick();
    #1 chk("mr_vld", 32'(bnk_add_vld), 32'b0010);
    tick();
    rst = 1'b1; tick();
    rst = 1'b0; req_vld = '0;
    #1;
    chk("mr_rdy", 32'(req_rdy), 32'h0);
    chk("mr_vld0", 32'(bnk_add_vld), 32'h0);
    chk("mr_gnt", 32'(bnk_gnt_idx), 32'h0);
    chk("mr_busy", 32'(bnk_busy), 32'h0);
    chk("mr_err", 32'(bnk_err), 32'h0);
    req_vld = 4'b1001; req_lst = 4'b1001; set_bid(0, 1); set_bid(3, 1);
    tick();
    #1;
    chk("mr_new_vld", 32'(bnk_add_vld), 32'b0010);
    chk("mr_new_gnt", 32'(bnk_gnt_idx[3:2]), 32'h0);
    tick();
    drain();

    // Randomized bursts; a requester keeps its bank until its last beat is accepted.
    for (int r = 0; r < RN; r++) g_left[r] = 0;
    repeat (3000) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int r = 0; r < RN; r++) begin
        if (g_left[r] == 0) begin
          g_bid[r]  = int'($urandom_range(0, 3));
          g_left[r] = int'($urandom_range(1, 4));
        end
        req_vld[r] = ($urandom_range(0, 3) != 0);
        req_lst[r] = (g_left[r] == 1);
        set_bid(r, g_bid[r]);
      end
      bnk_add_rdy = 4'($urandom);
      for (int b = 0; b < BN; b++)
        bnk_dat_ena[b] = (m_cnt[b] > 0) ? ($urandom_range(0, 1) == 1)
                                        : ($urandom_range(0, 59) == 0);
      tick();
      for (int r = 0; r < RN; r++) begin
        if (rst) g_left[r] = 0;
        else if (last_acc[r]) g_left[r] = g_left[r] - 1;
      end
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
